pe_act_queue_hs: RTL and testbench

PE_ACT_QUEUE_HS -- requirements
Module: pe_act_queue_hs

---
 rtl/pe_pkg.sv | 15 +
 rtl/pe_queue_ram.sv | 26 ++
 rtl/pe_act_queue_hs.sv | 97 +++++++++
 tb/tb_pe_act_queue_hs.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared PE definitions: activation queue defaults and a ceil-log2 helper.
package pe_pkg;

  localparam int PE_QUEUE_WIDTH = 32;
  localparam int PE_QUEUE_DEPTH = 16;

  // Ceil-log2, usable in parameter and port-width expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/pe_queue_ram.sv
// Activation queue storage: DEPTH x WIDTH, one write port, async read, no reset.
module pe_queue_ram
  import pe_pkg::*;
#(
  parameter int WIDTH = PE_QUEUE_WIDTH,
  parameter int DEPTH = PE_QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [clog2(DEPTH)-1:0]  wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [clog2(DEPTH)-1:0]  rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Async read gives the fall-through head word without a read cycle.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pe_act_queue_hs.sv
// First-word-fall-through activation queue with valid/ready handshakes,
// occupancy count, almost-full and sticky overflow flag.
module pe_act_queue_hs
  import pe_pkg::*;
#(
  parameter int WIDTH     = PE_QUEUE_WIDTH,
  parameter int DEPTH     = PE_QUEUE_DEPTH,
  parameter int AFULL_LVL = DEPTH - 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push_valid,
  output logic                    push_ready,
  input  logic [WIDTH-1:0]        act_in,
  output logic                    pop_valid,
  input  logic                    pop_ready,
  output logic [WIDTH-1:0]        act_out,
  output logic [clog2(DEPTH):0]   count,
  output logic                    almost_full,
  output logic                    overflow_err
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          push_fire, pop_fire;

  // Status outputs come only from registered state, so push_ready and
  // almost_full carry no combinational path from any input.
  assign push_ready   = (count_q != DEPTH_C);
  assign pop_valid    = (count_q != '0);
  assign count        = count_q;
  assign almost_full  = (count_q >= AFULL_C);
  assign overflow_err = ovf_q;

  // Handshakes and next-state: flush wins over any same-cycle push/pop.
  always_comb begin
    push_fire = push_valid & push_ready & ~flush;
    pop_fire  = pop_valid & pop_ready & ~flush;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_fire)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_fire, pop_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      // A push offered while full is dropped and flagged, even if a pop
      // frees a slot this cycle.
      if (push_valid && !push_ready) ovf_d = 1'b1;
    end
  end

  // State registers; reset overrides flush, push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  pe_queue_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push_fire & ~rst),
    .wr_addr (wr_ptr_q),
    .wr_data (act_in),
    .rd_addr (rd_ptr_q),
    .rd_data (act_out)
  );

endmodule

// File: tb/tb_pe_act_queue_hs.sv
// Bench for pe_act_queue_hs: directed scenarios plus random traffic checked
// against a queue-based reference model.
module tb_pe_act_queue_hs;

  localparam int W = 32;
  localparam int D = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          push_valid = 1'b0;
  logic          push_ready;
  logic [W-1:0]  act_in = '0;
  logic          pop_valid;
  logic          pop_ready = 1'b0;
  logic [W-1:0]  act_out;
  logic [4:0]    count;
  logic          almost_full;
  logic          overflow_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m_q[$];
  logic         m_err = 1'b0;

  always #5 clk = ~clk;

  pe_act_queue_hs #(.WIDTH(W), .DEPTH(D), .AFULL_LVL(D-2)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .push_valid   (push_valid),
    .push_ready   (push_ready),
    .act_in       (act_in),
    .pop_valid    (pop_valid),
    .pop_ready    (pop_ready),
    .act_out      (act_out),
    .count        (count),
    .almost_full  (almost_full),
    .overflow_err (overflow_err)
  );

  // Drive one cycle of inputs, clock it, advance the model, settle at negedge.
  task automatic cycle(input logic r, input logic fl, input logic pv,
                       input logic [W-1:0] d, input logic pr);
    bit full;
    rst = r; flush = fl; push_valid = pv; act_in = d; pop_ready = pr;
    @(posedge clk);
    full = (m_q.size() == D);
    if (r || fl) begin
      m_q.delete();
      m_err = 1'b0;
    end else begin
      if (pv && full) m_err = 1'b1;
      if (pr && m_q.size() != 0) void'(m_q.pop_front());
      if (pv && !full) m_q.push_back(d);
    end
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, '0, 0);
    n_checks++;
    if (count !== 5'd0 || pop_valid !== 1'b0 || push_ready !== 1'b1 ||
        almost_full !== 1'b0 || overflow_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: cnt=%0d pv=%b pr=%b af=%b err=%b, want 0 0 1 0 0",
               count, pop_valid, push_ready, almost_full, overflow_err);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= D; i++) begin
      cycle(0, 0, 1, W'(i), 0);
      n_checks++;
      if (count !== 5'(i) || almost_full !== (i >= D-2) || push_ready !== (i != D)) begin
        n_fail++;
        $display("FAIL fill[%0d]: cnt=%0d af=%b prdy=%b, want %0d %b %b",
                 i, count, almost_full, push_ready, i, (i >= D-2), (i != D));
      end
    end
    for (int i = 1; i <= D; i++) begin
      n_checks++;
      if (pop_valid !== 1'b1 || act_out !== W'(i)) begin
        n_fail++;
        $display("FAIL drain[%0d]: pv=%b out=%h, want 1 %h", i, pop_valid, act_out, W'(i));
      end
      cycle(0, 0, 0, '0, 1);
    end
    n_checks++;
    if (pop_valid !== 1'b0 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL drain_empty: pv=%b cnt=%0d, want 0 0", pop_valid, count);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < D; i++) cycle(0, 0, 1, $urandom, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 32'hDEAD, 0);
    n_checks++;
    if (overflow_err !== 1'b1 || count !== 5'd16 || push_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow: err=%b cnt=%0d prdy=%b, want 1 16 0", overflow_err, count, push_ready);
    end
    // Pop while pushing 0xDEAD on a full queue: still dropped, head order kept.
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (act_out !== m_q[0] || act_out === 32'hDEAD) begin
        n_fail++;
        $display("FAIL ovf_head[%0d]: out=%h, want %h", i, act_out, m_q[0]);
      end
      cycle(0, 0, (i == 0), 32'hDEAD, 1);
    end
    n_checks++;
    if (count !== 5'(m_q.size()) || count !== 5'd12) begin
      n_fail++;
      $display("FAIL ovf_count: cnt=%0d, want 12", count);
    end
    cycle(0, 1, 0, '0, 0);
    n_checks++;
    if (overflow_err !== 1'b0 || count !== 5'd0 || pop_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_flush: err=%b cnt=%0d pv=%b, want 0 0 0", overflow_err, count, pop_valid);
    end
  endtask

  task automatic test_empty_latency();
    cycle(0, 0, 1, 32'hABC, 0);
    n_checks++;
    if (pop_valid !== 1'b1 || act_out !== 32'hABC) begin
      n_fail++;
      $display("FAIL latency: pv=%b out=%h, want 1 00000abc", pop_valid, act_out);
    end
    cycle(0, 0, 0, '0, 1);
    cycle(0, 0, 0, '0, 1);
    cycle(0, 0, 0, '0, 1);
    n_checks++;
    if (count !== 5'd0 || overflow_err !== 1'b0 || pop_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_pop: cnt=%0d err=%b pv=%b, want 0 0 0", count, overflow_err, pop_valid);
    end
  endtask

  task automatic test_stream();
    int bad = 0;
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, $urandom, 0);
    for (int i = 0; i < 100; i++) begin
      if (act_out !== m_q[0] || count !== 5'd5) bad++;
      cycle(0, 0, 1, $urandom, 1);
    end
    n_checks++;
    if (bad != 0 || count !== 5'd5) begin
      n_fail++;
      $display("FAIL stream: bad_cycles=%0d cnt=%0d, want 0 5", bad, count);
    end
    cycle(0, 1, 0, '0, 0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) cycle(0, 0, 1, $urandom, 0);
    n_checks++;
    if (count !== 5'd9) begin
      n_fail++;
      $display("FAIL rst_mid_pre: cnt=%0d, want 9", count);
    end
    cycle(1, 0, 1, 32'h1234, 0);
    n_checks++;
    if (count !== 5'd0 || pop_valid !== 1'b0 || push_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid: cnt=%0d pv=%b prdy=%b, want 0 0 1", count, pop_valid, push_ready);
    end
  endtask

  task automatic test_flush_priority();
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 32'h100 + i, 0);
    cycle(0, 1, 1, 32'h5A5A, 1);
    n_checks++;
    if (count !== 5'd0 || pop_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_prio: cnt=%0d pv=%b, want 0 0", count, pop_valid);
    end
    cycle(0, 0, 1, 32'h77, 0);
    n_checks++;
    if (count !== 5'd1 || act_out !== 32'h77) begin
      n_fail++;
      $display("FAIL flush_after: cnt=%0d out=%h, want 1 00000077", count, act_out);
    end
    cycle(0, 1, 0, '0, 0);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 600; i++) begin
      if (count !== 5'(m_q.size()) || pop_valid !== (m_q.size() != 0) ||
          push_ready !== (m_q.size() != D) || almost_full !== (m_q.size() >= D-2) ||
          overflow_err !== m_err || (m_q.size() != 0 && act_out !== m_q[0])) begin
        if (bad < 5)
          $display("FAIL random[%0d]: cnt=%0d out=%h err=%b, want %0d %h %b",
                   i, count, act_out, overflow_err, m_q.size(),
                   (m_q.size() != 0) ? m_q[0] : '0, m_err);
        bad++;
      end
      // Bias push rate by phase so the queue visits empty and full regions.
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) == 0),
            ($urandom_range(0, 9) < ((i / 100) % 2 ? 8 : 3)), $urandom,
            ($urandom_range(0, 9) < 5));
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL random: bad_cycles=%0d, want 0", bad);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_overflow();
    test_empty_latency();
    test_stream();
    test_reset_mid();
    test_flush_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
